// File: rtl/lfsr_stim_pkg.sv
// Shared types and constants for the LFSR stimulus generator.
// The polynomial constant targets a 16-bit Galois LFSR only.
package lfsr_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
    localparam logic [15:0] LFSR_POLY16       = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

endpackage

// File: rtl/lfsr_core.sv
// 16-bit Galois LFSR state register with step enable and zero-guarded seed load.
// The low WIDTH bits of the state form the emitted word.
module lfsr_core
    import lfsr_stim_pkg::*;
#(
    parameter int                WIDTH  = 4,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_SEED_DEFAULT[LFSR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [WIDTH-1:0]  word
);

    localparam logic [LFSR_W-1:0] POLY = LFSR_POLY16[LFSR_W-1:0];

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_next;

    always_comb begin
        state_next = (state_q >> 1) ^ (state_q[0] ? POLY : '0);
    end

    // An all-zero seed would lock the register, so it is swapped for SEED
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else if (load) begin
            state_q <= (load_val == '0) ? SEED : load_val;
        end else if (step) begin
            state_q <= state_next;
        end
    end

    assign word = state_q[WIDTH-1:0];

endmodule

// File: rtl/lfsr_stim_gen.sv
// Burst-oriented pseudo-random word source on a valid/ready handshake.
// Holds the burst FSM, the latched length and the transferred-word counter.
module lfsr_stim_gen
    import lfsr_stim_pkg::*;
#(
    parameter int                WIDTH  = 4,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              start,
    input  logic [CNT_W-1:0]  burst_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  word_cnt
);

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             handshake;
    logic             seed_we;

    assign handshake = out_valid && out_ready;
    assign seed_we   = seed_load && (state == IDLE);
    assign cnt_inc   = word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    lfsr_core #(
        .WIDTH  (WIDTH),
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .step     (handshake),
        .load     (seed_we),
        .load_val (seed_in),
        .word     (out_data)
    );

    // Outputs are registered alongside the state so they never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            word_cnt  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= burst_len;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        if (burst_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            out_valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (handshake) begin
                        word_cnt <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
